branch_target_buffer: RTL and testbench

//   Direct-mapped branch target buffer and 2-bit predictor store; the table end of the branch unit's protocol.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/branch_target_buffer_entry_array.sv | 38 +++
 rtl/branch_target_buffer.sv | 132 +++++++++++++
 tb/tb_branch_target_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width, 2-bit predictor encodings and BTB
// sequencer states.
package cpu_pkg;

  localparam int PC_W = 32;

  // bit0 of every encoding is the predict-taken bit
  localparam logic [1:0] ST_SNT = 2'b00;
  localparam logic [1:0] ST_WNT = 2'b10;
  localparam logic [1:0] ST_WT  = 2'b01;
  localparam logic [1:0] ST_ST  = 2'b11;

  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_CLEAR = 1'b1
  } btb_state_e;

endpackage

// File: rtl/branch_target_buffer_entry_array.sv
// Tag/ctrl/target storage for the BTB: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module btb_entry_array #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [TAG_W-1:0] i_wtag,
  input  logic [1:0]       i_wctrl,
  input  logic [PC_W-1:0]  i_wtarget,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [TAG_W-1:0] o_rtag,
  output logic [1:0]       o_rctrl,
  output logic [PC_W-1:0]  o_rtarget
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [1:0]       r_ctrl   [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_waddr]    <= i_wtag;
      r_ctrl[i_waddr]   <= i_wctrl;
      r_target[i_waddr] <= i_wtarget;
    end
  end

  assign o_rtag    = r_tag[i_raddr];
  assign o_rctrl   = r_ctrl[i_raddr];
  assign o_rtarget = r_target[i_raddr];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit predictor state, one-cycle
// lookup, same-cycle write forwarding and a sequenced invalidate-all.
module branch_target_buffer
  import cpu_pkg::*;
#(
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lk_valid,
  input  logic [PC_W-1:0] lk_pc,
  output logic            pc_match_valid,
  output logic [1:0]      ctrl_state,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_we,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [1:0]      upd_ctrl,
  input  logic [PC_W-1:0] upd_target,
  input  logic            inv_all,
  output logic            busy,
  output logic            upd_dropped
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag, w_rd_tag, w_ent_tag;
  logic [1:0]       w_rd_ctrl, w_ent_ctrl;
  logic [PC_W-1:0]  w_rd_target, w_ent_target;
  logic             w_idle, w_wr_en, w_fwd, w_ent_valid, w_hit;
  logic [3:0]       w_unused_lsbs;

  btb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_clr_idx, w_clr_idx_nxt;
  logic [ENTRIES-1:0] r_valid;

  logic             r_pc_match_valid, r_upd_dropped;
  logic [1:0]       r_ctrl_state;
  logic [PC_W-1:0]  r_pred_target;

  // PC[1:0] never matters: instructions are word aligned
  assign w_unused_lsbs = {lk_pc[1:0], upd_pc[1:0]};
  assign w_lk_idx = lk_pc[IDX_W+1:2];
  assign w_lk_tag = lk_pc[PC_W-1:IDX_W+2];
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[PC_W-1:IDX_W+2];

  assign w_idle  = (r_state == BTB_IDLE);
  assign w_wr_en = upd_we && w_idle;

  btb_entry_array #(.IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)) u_array (
    .clk       (clk),
    .i_we      (w_wr_en),
    .i_waddr   (w_up_idx),
    .i_wtag    (w_up_tag),
    .i_wctrl   (upd_ctrl),
    .i_wtarget (upd_target),
    .i_raddr   (w_lk_idx),
    .o_rtag    (w_rd_tag),
    .o_rctrl   (w_rd_ctrl),
    .o_rtarget (w_rd_target)
  );

  // A write landing on the looked-up index this cycle wins over the array
  assign w_fwd        = w_wr_en && (w_up_idx == w_lk_idx);
  assign w_ent_valid  = w_fwd ? 1'b1       : r_valid[w_lk_idx];
  assign w_ent_tag    = w_fwd ? w_up_tag   : w_rd_tag;
  assign w_ent_ctrl   = w_fwd ? upd_ctrl   : w_rd_ctrl;
  assign w_ent_target = w_fwd ? upd_target : w_rd_target;
  assign w_hit = lk_valid && w_idle && w_ent_valid && (w_ent_tag == w_lk_tag);

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      BTB_IDLE: begin
        if (inv_all) w_state_nxt = BTB_CLEAR;
      end
      BTB_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == IDX_W'(ENTRIES - 1)) w_state_nxt = BTB_IDLE;
      end
      default: w_state_nxt = BTB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= BTB_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // An update in the same cycle as inv_all is written here, then cleared later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (!w_idle) begin
      r_valid[r_clr_idx] <= 1'b0;
    end else if (w_wr_en) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_match_valid <= 1'b0;
      r_ctrl_state     <= ST_SNT;
      r_pred_target    <= '0;
      r_upd_dropped    <= 1'b0;
    end else begin
      r_pc_match_valid <= w_hit;
      r_ctrl_state     <= w_hit ? w_ent_ctrl : ST_SNT;
      r_pred_target    <= w_hit ? w_ent_target : '0;
      r_upd_dropped    <= upd_we && !w_idle;
    end
  end

  assign pc_match_valid = r_pc_match_valid;
  assign ctrl_state     = r_ctrl_state;
  assign pred_taken     = r_ctrl_state[0] & r_pc_match_valid;
  assign pred_target    = r_pred_target;
  assign busy           = !w_idle;
  assign upd_dropped    = r_upd_dropped;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: a driver feeds directed and random
// traffic and queues the expected next-cycle response from a table-level model.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pc_match_valid;
  logic [1:0]  ctrl_state;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_we;
  logic [31:0] upd_pc;
  logic [1:0]  upd_ctrl;
  logic [31:0] upd_target;
  logic        inv_all;
  logic        busy;
  logic        upd_dropped;

  branch_target_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pc_match_valid(pc_match_valid), .ctrl_state(ctrl_state),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_we(upd_we), .upd_pc(upd_pc), .upd_ctrl(upd_ctrl), .upd_target(upd_target),
    .inv_all(inv_all), .busy(busy), .upd_dropped(upd_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [1:0]  ctrl;
    logic [31:0] tgt;
    logic        busy;
    logic        drop;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference table: stores the whole PC of the last write per slot
  bit          m_valid [16];
  logic [31:0] m_pc    [16];
  logic [1:0]  m_ctrl  [16];
  logic [31:0] m_tgt   [16];
  int          m_clear_left;
  int          m_clear_pos;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
    return (a / 64) == (b / 64);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_clear_left = 0;
    m_clear_pos  = 0;
  endtask

  task automatic step(input bit lv, input logic [31:0] lpc, input bit we,
                      input logic [31:0] upc, input logic [1:0] uc,
                      input logic [31:0] ut, input bit inv);
    exp_t e;
    bit   clearing;
    int   s;
    @(negedge clk);
    lk_valid = lv; lk_pc = lpc; upd_we = we; upd_pc = upc;
    upd_ctrl = uc; upd_target = ut; inv_all = inv;
    clearing = (m_clear_left > 0);
    e = '0;
    if (!clearing) begin
      if (we) begin
        s = slot(upc);
        m_valid[s] = 1'b1; m_pc[s] = upc; m_ctrl[s] = uc; m_tgt[s] = ut;
      end
      s = slot(lpc);
      if (lv && m_valid[s] && same_line(m_pc[s], lpc)) begin
        e.hit = 1'b1; e.ctrl = m_ctrl[s]; e.tgt = m_tgt[s];
      end
      if (inv) begin
        m_clear_left = 16;
        m_clear_pos  = 0;
      end
    end else begin
      e.drop = we;
      m_valid[m_clear_pos] = 1'b0;
      m_clear_pos++;
      m_clear_left--;
    end
    e.busy = (m_clear_left > 0);
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic write(input logic [31:0] pc, input logic [1:0] c, input logic [31:0] t);
    step(1'b0, 32'h0, 1'b1, pc, c, t, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    lk_valid = 0; upd_we = 0; inv_all = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_hit", {31'b0, pc_match_valid}, 32'h0);
    chk("rst_ctrl", {30'b0, ctrl_state}, 32'h0);
    chk("rst_target", pred_target, 32'h0);
    chk("rst_drop", {31'b0, upd_dropped}, 32'h0);
    model_reset();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("hit", {31'b0, pc_match_valid}, {31'b0, e.hit});
      chk("ctrl_state", {30'b0, ctrl_state}, {30'b0, e.ctrl});
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, e.hit & e.ctrl[0]});
      chk("pred_target", pred_target, e.tgt);
      chk("busy", {31'b0, busy}, {31'b0, e.busy});
      chk("upd_dropped", {31'b0, upd_dropped}, {31'b0, e.drop});
    end
  end

  initial begin
    logic [31:0] pc, t;
    rst_n = 1'b0; lk_valid = 0; lk_pc = 0; upd_we = 0; upd_pc = 0;
    upd_ctrl = 0; upd_target = 0; inv_all = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    look(32'h40);
    write(32'h40, 2'b01, 32'h100);
    look(32'h40);
    write(32'h80, 2'b10, 32'h300);
    look(32'h40);
    look(32'h80);
    step(1'b1, 32'h44, 1'b1, 32'h44, 2'b11, 32'h200, 1'b0);
    idle();

    for (int i = 0; i < 16; i++) write(32'h1000 + i * 4, 2'(i), 32'h8000 + i * 16);
    for (int i = 0; i < 16; i++) look(32'h1000 + i * 4);
    idle();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) step(1'b1, 32'h1000, 1'b1, 32'h1014, 2'b11, 32'hABC, 1'b0);
      else if (i == 9) step(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b1);
      else idle();
    end
    for (int i = 0; i < 16; i++) look(32'h1000 + i * 4);

    step(1'b0, 32'h0, 1'b1, 32'h48, 2'b01, 32'h444, 1'b1);
    repeat (16) idle();
    look(32'h48);

    for (int i = 0; i < 16; i++) write(32'h2000 + i * 4, 2'b11, 32'h9000 + i);
    step(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b1);
    repeat (5) idle();
    do_reset();
    for (int i = 0; i < 16; i++) look(32'h2000 + i * 4);
    write(32'h2008, 2'b10, 32'h7777);
    look(32'h2008);

    for (int n = 0; n < 400; n++) begin
      pc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      t  = $urandom;
      step(1'($urandom), ($urandom_range(0, 1) == 1) ? pc : {24'h0, 2'($urandom), 4'($urandom), 2'($urandom)},
           ($urandom_range(0, 2) == 0), {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)},
           2'($urandom), t, ($urandom_range(0, 49) == 0));
    end
    idle();
    idle();
    @(negedge clk);
    chk("queue_drained", q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
